// File: rtl/xor_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xor_sched : round-robin scheduler for four requesters sharing one XOR unit
// Rev 1.0
// ----------------------------------------------------------------------------
module xor_sched #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] a_bus,
    input  logic [4*N-1:0] b_bus,
    output logic [3:0]     gnt,
    output logic           busy,
    output logic [3:0]     done,
    output logic [N-1:0]   co,
    output logic [1:0]     co_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [1:0]   ptr_q,   ptr_d;
    logic [3:0]   gnt_q,   gnt_d;
    logic [3:0]   done_q,  done_d;
    logic [N-1:0] opa_q,   opa_d;
    logic [N-1:0] opb_q,   opb_d;
    logic [1:0]   widx_q,  widx_d;
    logic [N-1:0] co_q,    co_d;
    logic [1:0]   co_id_q, co_id_d;

    logic         arb_found;
    logic [1:0]   arb_win;
    logic [1:0]   arb_cand;

    // Scan from ptr upward with 2-bit wrap; first asserted request wins.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = ptr_q;
        arb_cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            arb_cand = ptr_q + 2'(k);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_win   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        widx_d  = widx_q;
        co_d    = co_q;
        co_id_d = co_id_q;
        case (state_q)
            S_IDLE: begin
                done_d = 4'b0000;
                if (arb_found) begin
                    state_d = S_EXEC;
                    gnt_d   = 4'b0001 << arb_win;
                    opa_d   = a_bus[32'(arb_win)*N +: N];
                    opb_d   = b_bus[32'(arb_win)*N +: N];
                    widx_d  = arb_win;
                end else begin
                    gnt_d = 4'b0000;
                end
            end
            S_EXEC: begin
                co_d    = opa_q ^ opb_q;
                co_id_d = widx_q;
                done_d  = 4'b0001 << widx_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Moving ptr past the winner gives it lowest priority next time.
                ptr_d   = widx_q + 2'd1;
                gnt_d   = 4'b0000;
                done_d  = 4'b0000;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 4'b0000;
                done_d  = 4'b0000;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            opa_q   <= '0;
            opb_q   <= '0;
            widx_q  <= 2'd0;
            co_q    <= '0;
            co_id_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            widx_q  <= widx_d;
            co_q    <= co_d;
            co_id_q <= co_id_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign co    = co_q;
    assign co_id = co_id_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xor_sched : directed vectors plus randomized traffic against a
// transaction-level model of the round-robin XOR scheduler. Rev 1.0
// ----------------------------------------------------------------------------
module tb_xor_sched;
    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           rstn  = 1'b1;
    logic [3:0]     req   = 4'b0000;
    logic [4*N-1:0] a_bus = '0;
    logic [4*N-1:0] b_bus = '0;
    logic [3:0]     gnt;
    logic           busy;
    logic [3:0]     done;
    logic [N-1:0]   co;
    logic [1:0]     co_id;

    xor_sched #(.N(N)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .a_bus (a_bus),
        .b_bus (b_bus),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .co    (co),
        .co_id (co_id)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: an operation occupies three consecutive edges
    // (start, result, release); the pointer moves past the winner at release.
    int           cyc       = 0;
    int           start_cyc = 0;
    int           act_w     = -1;
    int           mptr      = 0;
    logic [N-1:0] pend_co   = '0;
    logic [N-1:0] exp_co    = '0;
    logic [1:0]   exp_id    = 2'd0;
    logic [3:0]   exp_gnt   = 4'b0;
    logic [3:0]   exp_done  = 4'b0;
    logic         exp_busy  = 1'b0;

    typedef struct {
        logic [3:0]   req;
        int           id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_co;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        a_bus[i*N +: N] = a;
        b_bus[i*N +: N] = b;
    endtask

    task automatic model_reset();
        mptr     = 0;
        act_w    = -1;
        exp_co   = '0;
        exp_id   = 2'd0;
        exp_gnt  = 4'b0;
        exp_done = 4'b0;
        exp_busy = 1'b0;
    endtask

    task automatic model_edge();
        if (act_w >= 0 && cyc == start_cyc + 1) begin
            exp_co   = pend_co;
            exp_id   = 2'(act_w);
            exp_gnt  = 4'(1 << act_w);
            exp_done = 4'(1 << act_w);
            exp_busy = 1'b1;
        end else if (act_w >= 0) begin
            mptr     = (act_w + 1) % 4;
            act_w    = -1;
            exp_gnt  = 4'b0;
            exp_done = 4'b0;
            exp_busy = 1'b0;
        end else begin
            exp_gnt  = 4'b0;
            exp_done = 4'b0;
            exp_busy = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int c = (mptr + k) % 4;
                if (req[c]) begin
                    act_w     = c;
                    start_cyc = cyc;
                    pend_co   = a_bus[c*N +: N] ^ b_bus[c*N +: N];
                    exp_gnt   = 4'(1 << c);
                    exp_busy  = 1'b1;
                    break;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ":gnt"},   32'(gnt),   32'(exp_gnt));
        chk({tag, ":done"},  32'(done),  32'(exp_done));
        chk({tag, ":busy"},  32'(busy),  32'(exp_busy));
        chk({tag, ":co"},    32'(co),    32'(exp_co));
        chk({tag, ":co_id"}, 32'(co_id), 32'(exp_id));
    endtask

    task automatic wait_done(input string tag, output logic [3:0] d);
        d = 4'b0;
        for (int c = 0; c < 6; c++) begin
            step(tag);
            if (done != 4'b0) begin
                d = done;
                break;
            end
        end
        if (d == 4'b0) begin
            checks++;
            failures++;
            $display("FAIL %s:timeout actual=no_done required=done_within_6", tag);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst:gnt",   32'(gnt),   32'd0);
        chk("rst:done",  32'(done),  32'd0);
        chk("rst:busy",  32'(busy),  32'd0);
        chk("rst:co",    32'(co),    32'd0);
        chk("rst:co_id", 32'(co_id), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [3:0] d;
        logic [3:0] pend;
        pend = 4'b0;

        tbl[0] = '{4'b0001, 0, 4'hA, 4'h5, 4'hF};
        tbl[1] = '{4'b0010, 1, 4'h6, 4'h6, 4'h0};
        tbl[2] = '{4'b1000, 3, 4'h3, 4'hC, 4'hF};
        tbl[3] = '{4'b0100, 2, 4'hC, 4'h1, 4'hD};

        #2;
        do_reset();

        // Isolated single requests.
        for (int t = 0; t < 4; t++) begin
            set_op(tbl[t].id, tbl[t].a, tbl[t].b);
            req = tbl[t].req;
            step("vec_start");
            chk("vec:gnt_now", 32'(gnt), 32'(tbl[t].req));
            step("vec_result");
            chk("vec:done", 32'(done), 32'(tbl[t].req));
            chk("vec:co", 32'(co), 32'(tbl[t].exp_co));
            chk("vec:co_id", 32'(co_id), 32'(tbl[t].id));
            req = 4'b0;
            step("vec_release");
            chk("vec:busy_low", 32'(busy), 32'd0);
            step("vec_idle");
        end

        // All four requesting right after reset.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'hF);
        req = 4'b1111;
        for (int op = 0; op < 4; op++) begin
            wait_done("all", d);
            chk("all:order", 32'(d), 32'(1 << op));
            chk("all:co", 32'(co), 32'(4'hF - 4'(op)));
            chk("all:co_id", 32'(co_id), 32'(op));
        end
        req = 4'b0;
        repeat (3) step("all_drain");

        // Two persistent requesters must alternate.
        set_op(0, 4'h1, 4'h2);
        set_op(2, 4'h4, 4'h8);
        req = 4'b0101;
        for (int op = 0; op < 8; op++) begin
            wait_done("fair", d);
            chk("fair:alt", 32'(d), (op % 2 == 0) ? 32'h1 : 32'h4);
        end
        req = 4'b0;
        repeat (3) step("fair_drain");

        // Operands and request change after sampling.
        set_op(1, 4'h3, 4'h5);
        req = 4'b0010;
        step("opchg_start");
        set_op(1, 4'hF, 4'hF);
        req = 4'b0;
        step("opchg_result");
        chk("opchg:done", 32'(done), 32'h2);
        chk("opchg:co", 32'(co), 32'h6);
        chk("opchg:co_id", 32'(co_id), 32'd1);
        repeat (2) step("opchg_idle");

        // Reset in the middle of an operation.
        set_op(0, 4'h1, 4'h2);
        req = 4'b0001;
        step("rstmid_start");
        req = 4'b0100;
        set_op(2, 4'h5, 4'hA);
        do_reset();
        step("rstmid_g2");
        chk("rstmid:gnt2", 32'(gnt), 32'h4);
        step("rstmid_d2");
        chk("rstmid:done2", 32'(done), 32'h4);
        chk("rstmid:co", 32'(co), 32'hF);
        chk("rstmid:co_id", 32'(co_id), 32'd2);
        req = 4'b0;
        repeat (2) step("rstmid_idle");

        // Randomized traffic honouring hold-until-done.
        for (int c = 0; c < 400; c++) begin
            step("rand");
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    if (done[i]) begin
                        if ($urandom_range(1) == 1) begin
                            pend[i] = 1'b0;
                            req[i]  = 1'b0;
                        end else begin
                            set_op(i, N'($urandom), N'($urandom));
                        end
                    end else if (gnt[i] && $urandom_range(7) == 0) begin
                        pend[i] = 1'b0;
                        req[i]  = 1'b0;
                    end else if ($urandom_range(3) == 0) begin
                        set_op(i, N'($urandom), N'($urandom));
                    end
                end else if ($urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    req[i]  = 1'b1;
                    set_op(i, N'($urandom), N'($urandom));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
